// File: rtl/reg_sel_decoder_pkg.sv
// Shared types and helpers for the register-select decoder and its clear engine.
package reg_sel_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int outN(input int selW);
    return 1 << selW;
  endfunction

endpackage

// File: rtl/reg_sel_decoder_dec_onehot.sv
// Combinational one-hot decoder with optional reversed bit ordering.
module dec_onehot #(
  parameter int SEL_W   = 5,
  parameter bit REVERSE = 1'b0
) (
  input  logic                     en_i,
  input  logic [SEL_W-1:0]         idx_i,
  output logic [(1 << SEL_W)-1:0]  y_o
);

  logic [SEL_W-1:0] pos;

  // OUT_N-1-k equals the bitwise complement of k over SEL_W bits.
  assign pos = REVERSE ? ~idx_i : idx_i;

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[pos] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_sel_decoder.sv
// Registered one-hot write-select decoder with R0 protection and a sweep-all clear engine.
module reg_sel_decoder
  import reg_sel_decoder_pkg::*;
#(
  parameter int SEL_W          = 5,
  parameter bit REVERSE        = 1'b0,
  parameter bit PROTECT_ZERO   = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int OUT_N         = outN(SEL_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr_req,
  output logic [OUT_N-1:0] y,
  output logic             clr_active,
  output logic             clr_done,
  output logic             wr_drop
);

  localparam logic [SEL_W-1:0] CNT_LAST = '1;

  state_e           state_q;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             clrReq_q;
  logic             startPend_q;
  logic [OUT_N-1:0] y_q;
  logic             clrActive_q, clrDone_q, wrDrop_q;

  logic             reqEdge;
  logic             protHit;
  logic             decEn;
  logic [SEL_W-1:0] decIdx;
  logic [OUT_N-1:0] decOut;

  // The pending-start flag makes the first edge after reset look like a request edge.
  assign reqEdge = (clr_req & ~clrReq_q) | startPend_q;
  assign protHit = PROTECT_ZERO && (sel == '0);

  // The single decoder is shared: it decodes sel when idle and the sweep index when clearing.
  always_comb begin
    cnt_d  = cnt_q;
    decEn  = 1'b0;
    decIdx = sel;
    case (state_q)
      ST_IDLE: begin
        if (reqEdge) begin
          cnt_d  = '0;
          decEn  = 1'b1;
          decIdx = '0;
        end else begin
          decEn = en && !protHit;
        end
      end
      ST_CLEAR: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d  = cnt_q + SEL_W'(1);
          decEn  = 1'b1;
          decIdx = cnt_d;
        end
      end
      default: ;
    endcase
  end

  dec_onehot #(
    .SEL_W   (SEL_W),
    .REVERSE (REVERSE)
  ) u_dec (
    .en_i  (decEn),
    .idx_i (decIdx),
    .y_o   (decOut)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clrReq_q    <= 1'b0;
      startPend_q <= CLEAR_ON_RESET;
      y_q         <= '0;
      clrActive_q <= 1'b0;
      clrDone_q   <= 1'b0;
      wrDrop_q    <= 1'b0;
    end else begin
      clrReq_q    <= clr_req;
      startPend_q <= 1'b0;
      cnt_q       <= cnt_d;
      y_q         <= decOut;
      clrActive_q <= 1'b0;
      clrDone_q   <= 1'b0;
      wrDrop_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (reqEdge) begin
            state_q     <= ST_CLEAR;
            clrActive_q <= 1'b1;
            wrDrop_q    <= en;
          end else begin
            wrDrop_q <= en && protHit;
          end
        end
        ST_CLEAR: begin
          wrDrop_q <= en;
          if (cnt_q == CNT_LAST) begin
            state_q   <= ST_DONE;
            clrDone_q <= 1'b1;
          end else begin
            clrActive_q <= 1'b1;
          end
        end
        ST_DONE: begin
          wrDrop_q <= en;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign y          = y_q;
  assign clr_active = clrActive_q;
  assign clr_done   = clrDone_q;
  assign wr_drop    = wrDrop_q;

endmodule

// File: tb/tb_reg_sel_decoder.sv
// Scoreboarded random bench for reg_sel_decoder plus a directed legacy-ordering instance.
module tb_reg_sel_decoder;

  localparam int OUT_N = 32;

  typedef struct packed {
    logic [31:0] y;
    logic        act;
    logic        done;
    logic        drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN, en, clrReq;
  logic [4:0]  sel;
  logic [31:0] y;
  logic        clrActive, clrDone, wrDrop;

  logic        resetNL, enL, clrReqL;
  logic [2:0]  selL;
  logic [7:0]  yL;
  logic        clrActiveL, clrDoneL, wrDropL;

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  int   mSweep   = -1;
  bit   mDone    = 1'b0;
  bit   mPend    = 1'b0;
  bit   mReqPrev = 1'b0;

  always #5 clk = ~clk;

  reg_sel_decoder u_dut (
    .clk        (clk),
    .reset_n    (resetN),
    .en         (en),
    .sel        (sel),
    .clr_req    (clrReq),
    .y          (y),
    .clr_active (clrActive),
    .clr_done   (clrDone),
    .wr_drop    (wrDrop)
  );

  reg_sel_decoder #(
    .SEL_W          (3),
    .REVERSE        (1'b1),
    .PROTECT_ZERO   (1'b0),
    .CLEAR_ON_RESET (1'b0)
  ) u_leg (
    .clk        (clk),
    .reset_n    (resetNL),
    .en         (enL),
    .sel        (selL),
    .clr_req    (clrReqL),
    .y          (yL),
    .clr_active (clrActiveL),
    .clr_done   (clrDoneL),
    .wr_drop    (wrDropL)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference: a sweep presents indices 0..OUT_N-1, then one done cycle; any write meanwhile is dropped.
  task automatic modelStep(input bit e, input int s, input bit r, output exp_t x);
    bit edgeHit;
    edgeHit  = (r && !mReqPrev) || mPend;
    mPend    = 1'b0;
    mReqPrev = r;
    x        = '0;
    if (mSweep >= 0) begin
      x.drop = e;
      if (mSweep == OUT_N - 1) begin
        mSweep = -1;
        mDone  = 1'b1;
        x.done = 1'b1;
      end else begin
        mSweep++;
        x.y   = 32'd1 << mSweep;
        x.act = 1'b1;
      end
    end else if (mDone) begin
      mDone  = 1'b0;
      x.drop = e;
    end else if (edgeHit) begin
      mSweep = 0;
      x.y    = 32'd1;
      x.act  = 1'b1;
      x.drop = e;
    end else if (e) begin
      if (s == 0) x.drop = 1'b1;
      else        x.y    = 32'd1 << s;
    end
  endtask

  task automatic applyStimulus(input bit e, input int s, input bit r);
    exp_t x;
    en     = e;
    sel    = s[4:0];
    clrReq = r;
    modelStep(e, s, r, x);
    sbQ.push_back(x);
    @(negedge clk);
  endtask

  task automatic checkMainZero(input string tag);
    checkOutput({tag, "_y"},    y,                 32'd0);
    checkOutput({tag, "_act"},  {31'd0, clrActive}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, clrDone},   32'd0);
    checkOutput({tag, "_drop"}, {31'd0, wrDrop},    32'd0);
  endtask

  // Called at a negedge; asserts reset asynchronously, checks outputs, releases at a later negedge.
  task automatic mainReset(input bit e, input int s);
    resetN = 1'b0;
    en     = e;
    sel    = s[4:0];
    clrReq = 1'b0;
    sbQ.delete();
    #1;
    checkMainZero("rstAsync");
    repeat (2) @(posedge clk);
    #1;
    checkMainZero("rstHeld");
    @(negedge clk);
    resetN   = 1'b1;
    mSweep   = -1;
    mDone    = 1'b0;
    mPend    = 1'b1;
    mReqPrev = 1'b0;
  endtask

  task automatic legStep(input bit e, input int s, input bit r,
                         input logic [7:0] ey, input bit ea, input bit ed, input bit edr);
    enL     = e;
    selL    = s[2:0];
    clrReqL = r;
    @(posedge clk);
    #1;
    checkOutput("leg_y",    {24'd0, yL},         {24'd0, ey});
    checkOutput("leg_act",  {31'd0, clrActiveL}, {31'd0, ea});
    checkOutput("leg_done", {31'd0, clrDoneL},   {31'd0, ed});
    checkOutput("leg_drop", {31'd0, wrDropL},    {31'd0, edr});
    @(negedge clk);
  endtask

  // Monitor: every presented output cycle is matched against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (resetN === 1'b1 && sbQ.size() > 0) begin
        x = sbQ.pop_front();
        checkOutput("y",       y,                  x.y);
        checkOutput("clrAct",  {31'd0, clrActive}, {31'd0, x.act});
        checkOutput("clrDone", {31'd0, clrDone},   {31'd0, x.done});
        checkOutput("wrDrop",  {31'd0, wrDrop},    {31'd0, x.drop});
        checkOutput("onehot0", {31'd0, $onehot0(y)}, 32'd1);
        checkOutput("actDoneExcl", {31'd0, clrActive & clrDone}, 32'd0);
      end
    end
  end

  initial begin
    bit rLvl;
    resetN  = 1'b0;
    en      = 1'b0;
    sel     = '0;
    clrReq  = 1'b0;
    resetNL = 1'b0;
    enL     = 1'b1;
    selL    = 3'd5;
    clrReqL = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("legRst_y",    {24'd0, yL},        32'd0);
    checkOutput("legRst_flags", {29'd0, clrActiveL, clrDoneL, wrDropL}, 32'd0);
    resetNL = 1'b1;
    legStep(1'b1, 5, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
    legStep(1'b1, 0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    legStep(1'b1, 7, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    legStep(1'b0, 0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      legStep(1'b0, 0, 1'b1, 8'h80 >> i, 1'b1, 1'b0, 1'b0);
    end
    legStep(1'b1, 2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    legStep(1'b0, 0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    legStep(1'b1, 3, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    mainReset(1'b1, 5);
    for (int i = 0; i < 34; i++) begin
      if (i == 4) applyStimulus(1'b1, 9, 1'b0);
      else        applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b0);
    end
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 31, 1'b0);

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31)), 1'b0);
    end

    applyStimulus(1'b0, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b1);
    end
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);

    applyStimulus(1'b0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
    end
    mainReset(1'b0, 0);
    for (int i = 0; i < 36; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
    end

    rLvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rLvl = ~rLvl;
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 31)), rLvl);
    end

    @(posedge clk);
    #2;
    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
